// File: rtl/spectrum_avg_stream.sv
// Power-spectrum averager: |X|^2 per FFT bin, accumulated over 2^LOG2_AVG frames,
// emitted as one averaged AXI-Stream frame per averaging window.
module spectrum_avg_stream #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 1024,
    parameter int LOG2_AVG  = 2,
    parameter int OUT_W     = 32
) (
    input  logic                I_CLOCK,
    input  logic                I_RESETN,
    input  logic                S_I_DATA_VALID,
    output logic                S_O_DATA_READY,
    input  logic [2*DATA_W-1:0] S_I_DATA,
    input  logic                S_I_DATA_TLAST,
    output logic                M_O_DATA_VALID,
    input  logic                M_I_DATA_READY,
    output logic [OUT_W-1:0]    M_O_DATA,
    output logic                M_O_DATA_TLAST,
    output logic                O_FRAME_ERR
);

    localparam int BIN_W  = $clog2(FRAME_LEN);
    localparam int MAG_W  = 2*DATA_W + 1;
    localparam int ACC_W  = MAG_W + LOG2_AVG;
    localparam int FRM_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(FRAME_LEN - 1);
    localparam logic [FRM_W-1:0]  LAST_FRM = FRM_W'((1 << LOG2_AVG) - 1);
    localparam logic [WIDE_W-1:0] MAX_OUT  = (WIDE_W'(1) << OUT_W) - WIDE_W'(1);

    function automatic logic [MAG_W-1:0] power(input logic [2*DATA_W-1:0] beat);
        logic signed [DATA_W-1:0]   re;
        logic signed [DATA_W-1:0]   im;
        logic signed [2*DATA_W-1:0] re_sq;
        logic signed [2*DATA_W-1:0] im_sq;
        re    = beat[DATA_W-1:0];
        im    = beat[2*DATA_W-1:DATA_W];
        re_sq = (2*DATA_W)'(re) * (2*DATA_W)'(re);
        im_sq = (2*DATA_W)'(im) * (2*DATA_W)'(im);
        // Squares are never negative, so a zero MSB extension is exact.
        return {1'b0, re_sq} + {1'b0, im_sq};
    endfunction

    function automatic logic [OUT_W-1:0] sat_avg(input logic [ACC_W-1:0] sum);
        logic [WIDE_W-1:0] q;
        q = WIDE_W'(sum) >> LOG2_AVG;
        if (q > MAX_OUT) return '1;
        else             return q[OUT_W-1:0];
    endfunction

    logic             en, accept, is_last_bin, frame_end, frame_err;
    logic [BIN_W-1:0] bin_cnt;
    logic [FRM_W-1:0] frm_cnt;

    logic             vld_p1, first_p1, final_p1, last_p1;
    logic [MAG_W-1:0] mag_p1;
    logic [BIN_W-1:0] bin_p1;
    logic [ACC_W-1:0] sum_p1;
    logic [ACC_W-1:0] acc_mem [FRAME_LEN];

    assign en             = !M_O_DATA_VALID || M_I_DATA_READY;
    assign S_O_DATA_READY = en && I_RESETN;
    assign accept         = S_I_DATA_VALID && S_O_DATA_READY;
    assign is_last_bin    = (bin_cnt == LAST_BIN);
    assign frame_end      = accept && (is_last_bin || S_I_DATA_TLAST);
    assign frame_err      = accept && (is_last_bin != S_I_DATA_TLAST);

    // An erroneous beat closes the frame and abandons the running average.
    always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            bin_cnt     <= '0;
            frm_cnt     <= '0;
            O_FRAME_ERR <= 1'b0;
        end else begin
            O_FRAME_ERR <= frame_err;
            if (frame_end)   bin_cnt <= '0;
            else if (accept) bin_cnt <= bin_cnt + BIN_W'(1);
            if (frame_err)      frm_cnt <= '0;
            else if (frame_end) frm_cnt <= (frm_cnt == LAST_FRM) ? '0 : frm_cnt + FRM_W'(1);
        end
    end

    // ---- stage 1: power and frame-position tags ----
    always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            vld_p1   <= 1'b0;
            mag_p1   <= '0;
            bin_p1   <= '0;
            first_p1 <= 1'b0;
            final_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else if (en) begin
            vld_p1 <= accept;
            if (accept) begin
                mag_p1   <= power(S_I_DATA);
                bin_p1   <= bin_cnt;
                first_p1 <= (frm_cnt == '0);
                final_p1 <= (frm_cnt == LAST_FRM);
                last_p1  <= frame_end;
            end
        end
    end

    // ---- stage 2: accumulate, or average into the output register ----
    assign sum_p1 = (first_p1 ? '0 : acc_mem[bin_p1]) + ACC_W'(mag_p1);

    always_ff @(posedge I_CLOCK) begin
        if (en && vld_p1 && !final_p1) acc_mem[bin_p1] <= sum_p1;
    end

    always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            M_O_DATA_VALID <= 1'b0;
            M_O_DATA       <= '0;
            M_O_DATA_TLAST <= 1'b0;
        end else if (en) begin
            if (vld_p1 && final_p1) begin
                M_O_DATA_VALID <= 1'b1;
                M_O_DATA       <= sat_avg(sum_p1);
                M_O_DATA_TLAST <= last_p1;
            end else begin
                M_O_DATA_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_avg_stream.sv
// Scoreboard bench for spectrum_avg_stream: averaging, backpressure, framing errors,
// mid-frame reset, and output saturation on a narrow-output LOG2_AVG=0 instance.
`timescale 1ns/1ps
module tb_spectrum_avg_stream;

    localparam int FL   = 4;
    localparam int LOG2 = 2;
    localparam int NAVG = 1 << LOG2;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last, frame_err;
    logic [31:0] m_data;

    logic        z_valid, z_ready, z_last, zm_valid, zm_ready, zm_last, z_err;
    logic [31:0] z_data;
    logic [30:0] zm_data;

    int     n_checks = 0;
    int     n_err    = 0;
    int     mbin = 0, mfrm = 0;
    longint macc [FL];
    exp_t   exp_q[$];
    exp_t   zq[$];
    int     out_beats = 0;
    bit     stall_phase = 0, rand_bp = 0;

    always #5 clk = ~clk;

    spectrum_avg_stream #(.DATA_W(16), .FRAME_LEN(FL), .LOG2_AVG(LOG2), .OUT_W(32)) u_dut (
        .I_CLOCK(clk), .I_RESETN(rst_n),
        .S_I_DATA_VALID(s_valid), .S_O_DATA_READY(s_ready),
        .S_I_DATA(s_data), .S_I_DATA_TLAST(s_last),
        .M_O_DATA_VALID(m_valid), .M_I_DATA_READY(m_ready),
        .M_O_DATA(m_data), .M_O_DATA_TLAST(m_last),
        .O_FRAME_ERR(frame_err)
    );

    spectrum_avg_stream #(.DATA_W(16), .FRAME_LEN(FL), .LOG2_AVG(0), .OUT_W(31)) u_sat (
        .I_CLOCK(clk), .I_RESETN(rst_n),
        .S_I_DATA_VALID(z_valid), .S_O_DATA_READY(z_ready),
        .S_I_DATA(z_data), .S_I_DATA_TLAST(z_last),
        .M_O_DATA_VALID(zm_valid), .M_I_DATA_READY(zm_ready),
        .M_O_DATA(zm_data), .M_O_DATA_TLAST(zm_last),
        .O_FRAME_ERR(z_err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model of the averager, advanced once per accepted beat.
    task automatic model_accept(input int re, input int im, input bit tl, output bit err);
        longint mag, sum;
        bit     lastbin, fend;
        exp_t   e;
        mag     = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        lastbin = (mbin == FL - 1);
        fend    = lastbin || tl;
        err     = (lastbin != tl);
        sum     = ((mfrm == 0) ? 64'sd0 : macc[mbin]) + mag;
        if (mfrm == NAVG - 1) begin
            e.data = 64'(sum >> LOG2);
            if (e.data > 64'hFFFF_FFFF) e.data = 64'hFFFF_FFFF;
            e.last = fend;
            exp_q.push_back(e);
        end else begin
            macc[mbin] = sum;
        end
        mbin = fend ? 0 : mbin + 1;
        if (err)       mfrm = 0;
        else if (fend) mfrm = (mfrm + 1) % NAVG;
    endtask

    // Called and returns at a falling edge.
    task automatic send(input int re, input int im, input bit tl);
        bit   rdy, done, err_e;
        int   waits;
        logic [15:0] re16, im16;
        re16 = re[15:0];
        im16 = im[15:0];
        s_data  = {im16, re16};
        s_last  = tl;
        s_valid = 1'b1;
        done = 0; waits = 0; err_e = 0;
        while (!done && waits < 200) begin
            rdy = s_ready;
            @(posedge clk);
            if (rdy) done = 1;
            else begin
                @(negedge clk);
                waits++;
            end
        end
        if (!done) begin
            check("send_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
        end else begin
            model_accept(re, im, tl, err_e);
            @(negedge clk);
            s_valid = 1'b0;
            check("frame_err", 64'(frame_err), 64'(err_e));
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic frame_const(input int re, input int im);
        for (int b = 0; b < FL; b++) send(re, im, b == FL - 1);
    endtask

    task automatic frame_rand();
        for (int b = 0; b < FL; b++) send(rnd(), rnd(), b == FL - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Downstream sink: one fixed 5-cycle stall on demand, optional random gaps.
    initial begin
        int hold_cnt;
        hold_cnt = 0;
        m_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_phase && hold_cnt < 5 && m_valid) begin
                m_ready = 1'b0;
                hold_cnt++;
            end else begin
                m_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Output monitor for the main instance.
    initial begin
        bit          stall_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        exp_t        e;
        stall_prev = 0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_data", 64'(m_data), 64'(prev_data));
                    check("hold_last", 64'(m_last), 64'(prev_last));
                end
                stall_prev = m_valid && !m_ready;
                if (stall_prev) begin
                    prev_data = m_data;
                    prev_last = m_last;
                    check("stall_s_ready", 64'(s_ready), 64'd0);
                end
                if (m_valid && m_ready) begin
                    out_beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(m_data), e.data);
                        check("out_last", 64'(m_last), 64'(e.last));
                    end
                end
            end
        end
    end

    // Output monitor for the saturating instance (sink always ready).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && zm_valid) begin
                if (zq.size() == 0) begin
                    check("sat_unexpected", 64'(zm_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = zq.pop_front();
                    check("sat_data", 64'(zm_data), e.data);
                    check("sat_last", 64'(zm_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int   b0;
        exp_t e;
        int   zre[4];
        int   zim[4];
        logic [15:0] r16, i16;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        z_valid = 1'b0; z_data = '0; z_last = 1'b0; zm_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_idle", 64'(s_ready), 64'd1);

        // Constant 3+4j: every averaged bin is 25, TLAST on the 4th beat.
        b0 = out_beats;
        repeat (NAVG) frame_const(3, 4);
        drain();
        check("t1_beats", 64'(out_beats - b0), 64'(FL));

        // bin0 powers 8,16,20,36 average to 20; next window must not carry over.
        send(2, 2, 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        send(4, 0, 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        send(4, 2, 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        send(6, 0, 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        drain();
        repeat (NAVG) frame_const(1, 0);
        drain();

        // Five-cycle downstream stall mid-output, then random backpressure.
        stall_phase = 1;
        b0 = out_beats;
        repeat (NAVG) frame_rand();
        drain();
        check("t3_beats", 64'(out_beats - b0), 64'(FL));
        stall_phase = 0;
        rand_bp = 1;
        repeat (2 * NAVG) frame_rand();
        drain();
        rand_bp = 0;

        // Early TLAST in frame 1, then a clean window of four frames.
        frame_rand();
        send(rnd(), rnd(), 0); send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        repeat (NAVG) frame_rand();
        drain();
        // Missing TLAST, then an early TLAST inside the final frame.
        for (int b = 0; b < FL; b++) send(rnd(), rnd(), 0);
        repeat (NAVG - 1) frame_rand();
        b0 = out_beats;
        send(rnd(), rnd(), 0); send(rnd(), rnd(), 1);
        drain();
        check("short_final_beats", 64'(out_beats - b0), 64'd2);
        repeat (NAVG) frame_rand();
        drain();

        // Most negative components: power 2^31 fits a 32-bit output.
        repeat (NAVG) frame_const(-32768, -32768);
        drain();

        // Reset in the middle of frame 2.
        frame_rand(); frame_rand();
        send(rnd(), rnd(), 0); send(rnd(), rnd(), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", 64'(m_data), 64'd0);
        check("mid_rst_m_last", 64'(m_last), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        mbin = 0; mfrm = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b0 = out_beats;
        repeat (NAVG) frame_rand();
        drain();
        check("post_rst_beats", 64'(out_beats - b0), 64'(FL));

        // Narrow-output, no-averaging instance: 2^31 saturates to 2^31-1.
        zre = '{-32768, 3, -32768, 100};
        zim = '{-32768, 4, 0, -100};
        e.data = 64'd2147483647; e.last = 1'b0; zq.push_back(e);
        e.data = 64'd25;         e.last = 1'b0; zq.push_back(e);
        e.data = 64'd1073741824; e.last = 1'b0; zq.push_back(e);
        e.data = 64'd20000;      e.last = 1'b1; zq.push_back(e);
        z_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r16 = zre[i][15:0];
            i16 = zim[i][15:0];
            z_data = {i16, r16};
            z_last = (i == 3);
            check("sat_in_ready", 64'(z_ready), 64'd1);
            @(negedge clk);
        end
        z_valid = 1'b0;
        z_last  = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_drained", 64'(zq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
